rc4_prga_decrypt: RTL and testbench
===================================

RC4_PRGA_DECRYPT -- requirements
Module: rc4_prga_decrypt

Interface
REQ-001 Parameter: MSG_LEN, default 32, number of ciphertext bytes decrypted per run (range 1..32).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous and active-low.
REQ-004 start  in  1  one-cycle pulse; begins a decrypt run, sampled in IDLE, DONE or FAIL only.
REQ-005 s_addr / s_wdata / s_wren  out  8/8/1  S-box RAM port; read data s_rdata is valid the cycle after s_addr is presented.
REQ-006 s_rdata  in  8  S-box RAM read data.
REQ-007 rom_addr  out  5; rom_rdata  in  8  ciphertext ROM; one-cycle read latency.
REQ-008 d_addr / d_wdata / d_wren  out  5/8/1  decrypted-message RAM write port.
REQ-009 chk_start  out  1  one-cycle pulse to the downstream message checker.
REQ-010 chk_restart  out  1  one-cycle pulse clearing the checker's sticky key_is_wrong.
REQ-011 chk_data  out  8  plaintext byte to the checker.
REQ-012 chk_finish  in  1  checker accepted the byte.
REQ-013 chk_key_wrong  in  1  checker rejected the byte.
REQ-014 done  out  1  run finished, level, held until next start.
REQ-015 key_ok  out  1  valid only while done=1; 1 = all MSG_LEN bytes passed.

Function
REQ-016 Per run: i=0, j=0; for k=0..MSG_LEN-1: i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[(S[i]+S[j]) mod 256]; P[k]=f XOR C[k]; all index arithmetic 8-bit, wrapping mod 256.
REQ-017 States: IDLE, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_F, RD_C, WR_OUT, CHK, WAIT_CHK, DONE, FAIL.
REQ-018 IDLE/DONE/FAIL + start: clear i, j, k; drop done; pulse chk_restart in the same cycle; go to RD_SI.
REQ-019 RD_SI: drive s_addr=i+1, latch new i -> RD_SJ (captures S[i] next cycle, computes j=j+S[i], drives s_addr=j).
REQ-020 WR_SI: write S[i]=S[j] (old); WR_SJ: write S[j]=S[i] (old); the swap uses values latched before either write; i==j writes the same value twice.
REQ-021 RD_F: drive s_addr=S[i]+S[j] using post-swap values; RD_C: drive rom_addr=k, capture f.
REQ-022 WR_OUT: d_addr=k, d_wdata=f XOR rom_rdata, d_wren=1 for exactly one cycle; register the byte onto chk_data.
REQ-023 CHK: chk_start=1 for one cycle; chk_data is held stable from CHK until the checker responds.
REQ-024 WAIT_CHK: chk_key_wrong=1 -> FAIL (takes priority if chk_finish=1 in the same cycle); chk_finish=1 with k=MSG_LEN-1 -> DONE; chk_finish=1 otherwise -> k=k+1, RD_SI; wait indefinitely otherwise.
REQ-025 DONE: done=1, key_ok=1; FAIL: done=1, key_ok=0; no further memory writes after entering either state.
REQ-026 s_wren and d_wren are never both asserted with a read address change in the same cycle; s_wren is high only in WR_SI/WR_SJ.
REQ-027 start while a run is in progress (not IDLE/DONE/FAIL) is ignored.
REQ-028 Minimum loop time per byte, checker responding in one cycle: 10 cycles.

Reset
REQ-029 rst_n=0 at a rising edge: state=IDLE; i, j, k=0; done=0; key_ok=0; chk_start=0; chk_restart=0; chk_data=0; s_wren=0; d_wren=0; all addresses 0.
REQ-030 Reset mid-run aborts immediately with no further writes; S-box RAM contents are not restored.

Verification
REQ-031 S[x]=x, C[0]=0x63, C[1]=0x66, MSG_LEN=2, checker model accepts -> d[0]=0x61 ('a'), d[1]=0x63 after swap S[2]=3, S[3]=2, f=S[5]=5; done=1, key_ok=1.
REQ-032 Checker asserts chk_key_wrong on byte 0 -> FAIL, done=1, key_ok=0, exactly one d_wren and one chk_start pulse observed.
REQ-033 Checker delays chk_finish by 5 cycles -> chk_data is stable throughout, and no S or D write occurs during the wait.
REQ-034 S built so that i==j at k=0 -> both swap writes carry the same value and S is unchanged at that index.
REQ-035 rst_n=0 asserted while in WR_SI -> next cycle all outputs are at their REQ-029 values; a subsequent start runs cleanly with chk_restart pulsed.
REQ-036 start pulsed mid-run -> ignored; start in DONE -> chk_restart pulse, done drops next cycle, new run with i=j=k=0.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// rtl/rc4_prga_decrypt.sv - RC4 PRGA keystream decryptor driving an S-box RAM, ciphertext ROM and message checker
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    input  logic [7:0] s_rdata,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_rdata,
    output logic [4:0] d_addr,
    output logic [7:0] d_wdata,
    output logic       d_wren,
    output logic       chk_start,
    output logic       chk_restart,
    output logic [7:0] chk_data,
    input  logic       chk_finish,
    input  logic       chk_key_wrong,
    output logic       done,
    output logic       key_ok
);

    localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        RD_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        RD_C,
        WR_OUT,
        CHK,
        WAIT_CHK,
        DONE,
        FAIL
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [4:0] k_q, k_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] f_q, f_d;
    logic [7:0] chk_data_q, chk_data_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            k_q        <= 5'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            f_q        <= 8'd0;
            chk_data_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            f_q        <= f_d;
            chk_data_q <= chk_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        si_d        = si_q;
        sj_d        = sj_q;
        f_d         = f_q;
        chk_data_d  = chk_data_q;
        s_addr      = 8'd0;
        s_wdata     = 8'd0;
        s_wren      = 1'b0;
        rom_addr    = 5'd0;
        d_addr      = 5'd0;
        d_wdata     = 8'd0;
        d_wren      = 1'b0;
        chk_start   = 1'b0;
        chk_restart = 1'b0;

        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    i_d         = 8'd0;
                    j_d         = 8'd0;
                    k_d         = 5'd0;
                    chk_restart = 1'b1;
                    state_d     = RD_SI;
                end
            end
            RD_SI: begin
                s_addr  = i_q + 8'd1;
                i_d     = i_q + 8'd1;
                state_d = RD_SJ;
            end
            // s_rdata now holds S[i]; the new j is presented as the next read address
            RD_SJ: begin
                si_d    = s_rdata;
                j_d     = j_q + s_rdata;
                s_addr  = j_q + s_rdata;
                state_d = WR_SI;
            end
            WR_SI: begin
                sj_d    = s_rdata;
                s_addr  = i_q;
                s_wdata = s_rdata;
                s_wren  = 1'b1;
                state_d = WR_SJ;
            end
            WR_SJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = RD_F;
            end
            // post-swap S[i]+S[j] equals the pre-swap sum, so the latched pair serves
            RD_F: begin
                s_addr  = si_q + sj_q;
                state_d = RD_C;
            end
            RD_C: begin
                rom_addr = k_q;
                f_d      = s_rdata;
                state_d  = WR_OUT;
            end
            WR_OUT: begin
                d_addr     = k_q;
                d_wdata    = f_q ^ rom_rdata;
                d_wren     = 1'b1;
                chk_data_d = f_q ^ rom_rdata;
                state_d    = CHK;
            end
            CHK: begin
                chk_start = 1'b1;
                state_d   = WAIT_CHK;
            end
            WAIT_CHK: begin
                if (chk_key_wrong) begin
                    state_d = FAIL;
                end else if (chk_finish) begin
                    if (k_q == LAST_K) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 5'd1;
                        state_d = RD_SI;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign chk_data = chk_data_q;
    assign done     = (state_q == DONE) || (state_q == FAIL);
    assign key_ok   = (state_q == DONE);

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb/tb_rc4_prga_decrypt.sv - self-checking bench for rc4_prga_decrypt against an RC4 reference model
module tb_rc4_prga_decrypt;

    localparam int MSG_LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] s_addr, s_wdata, s_rdata;
    logic       s_wren;
    logic [4:0] rom_addr, d_addr;
    logic [7:0] rom_rdata, d_wdata, chk_data;
    logic       d_wren, chk_start, chk_restart, chk_finish, chk_key_wrong, done, key_ok;

    always #5 clk = ~clk;

    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_wren       (s_wren),
        .s_rdata      (s_rdata),
        .rom_addr     (rom_addr),
        .rom_rdata    (rom_rdata),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wren       (d_wren),
        .chk_start    (chk_start),
        .chk_restart  (chk_restart),
        .chk_data     (chk_data),
        .chk_finish   (chk_finish),
        .chk_key_wrong(chk_key_wrong),
        .done         (done),
        .key_ok       (key_ok)
    );

    logic [7:0] sram   [256];
    logic [7:0] load_s [256];
    logic       load_req = 1'b0;
    logic [7:0] rom    [32];
    logic [7:0] d_mem  [32];

    always @(posedge clk) begin
        if (load_req) begin
            for (int x = 0; x < 256; x++) sram[x] <= load_s[x];
        end else if (s_wren) begin
            sram[s_addr] <= s_wdata;
        end
        s_rdata   <= sram[s_addr];
        rom_rdata <= rom[rom_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_p       [32];
    logic [7:0] exp_sw_addr [64];
    logic [7:0] exp_sw_data [64];
    logic [7:0] exp_s       [256];
    int exp_n_sw, exp_nb;

    int n_sw, n_dw, n_starts;
    bit run_active = 1'b0;
    bit pend = 1'b0, resp_rej = 1'b0, timing_chk = 1'b0;
    int wait_cnt, chk_delay, reject_idx, last_start_cyc;
    logic [7:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // RC4 PRGA over a copy of the current S-box RAM, stopping after the rejected byte if any
    task automatic build_model(input int rej);
        logic [7:0] s [256];
        logic [7:0] i8, j8, a, b, t;
        int nb;
        nb = (rej >= 0) ? rej + 1 : MSG_LEN;
        for (int x = 0; x < 256; x++) s[x] = sram[x];
        i8 = 0; j8 = 0; exp_n_sw = 0;
        for (int k = 0; k < nb; k++) begin
            i8 = i8 + 8'd1;
            j8 = j8 + s[i8];
            a = s[i8]; b = s[j8];
            exp_sw_addr[exp_n_sw] = i8; exp_sw_data[exp_n_sw] = b; exp_n_sw++;
            exp_sw_addr[exp_n_sw] = j8; exp_sw_data[exp_n_sw] = a; exp_n_sw++;
            s[i8] = b; s[j8] = a;
            t = s[i8] + s[j8];
            exp_p[k] = s[t] ^ rom[k];
        end
        exp_nb = nb;
        for (int x = 0; x < 256; x++) exp_s[x] = s[x];
    endtask

    // one cycle: sample at the falling edge, score writes, emulate the checker
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk_finish    = 1'b0;
        chk_key_wrong = 1'b0;
        if (!run_active) begin
            check("no_write_outside_run", {s_wren, d_wren}, 2'b00);
        end else begin
            if (s_wren) begin
                if (n_sw < exp_n_sw) begin
                    check("s_wr_addr", s_addr, exp_sw_addr[n_sw]);
                    check("s_wr_data", s_wdata, exp_sw_data[n_sw]);
                end
                n_sw++;
            end
            if (d_wren) begin
                if (n_dw < 32) begin
                    check("d_wr_addr", d_addr, 5'(n_dw));
                    check("d_wr_data", d_wdata, exp_p[n_dw]);
                    d_mem[d_addr] = d_wdata;
                end
                n_dw++;
            end
        end
        if (pend) begin
            check("wait_no_writes", {s_wren, d_wren}, 2'b00);
            check("wait_chk_data_stable", chk_data, held);
            if (wait_cnt == 0) begin
                pend = 1'b0;
                chk_finish = 1'b1;
                if (resp_rej) chk_key_wrong = 1'b1;
            end else begin
                wait_cnt--;
            end
        end
        if (chk_start) begin
            if (n_starts < 32) check("chk_data", chk_data, exp_p[n_starts]);
            if (timing_chk && last_start_cyc >= 0) check("loop_cycles", cyc - last_start_cyc, 10);
            last_start_cyc = cyc;
            held = chk_data;
            resp_rej = (n_starts == reject_idx);
            pend = 1'b1;
            wait_cnt = chk_delay;
            n_starts++;
        end
    endtask

    task automatic load_sbox(input bit ident);
        for (int x = 0; x < 256; x++) load_s[x] = ident ? 8'(x) : 8'($urandom_range(0, 255));
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic begin_run(input int dly, input int rej);
        build_model(rej);
        chk_delay = dly; reject_idx = rej;
        n_sw = 0; n_dw = 0; n_starts = 0; pend = 1'b0; last_start_cyc = -1;
        run_active = 1'b1;
        start = 1'b1;
        #1;
        check("chk_restart_pulse", chk_restart, 1'b1);
        tick();
        start = 1'b0;
        check("done_dropped", done, 1'b0);
    endtask

    task automatic run(input int dly, input int rej, input bit mid);
        int g;
        begin_run(dly, rej);
        if (mid) begin
            repeat (3) tick();
            start = 1'b1;
            #1;
            check("mid_start_ignored", chk_restart, 1'b0);
            tick();
            start = 1'b0;
        end
        g = 0;
        while (!done && g < 2000) begin
            tick();
            g++;
        end
        check("run_done", done, 1'b1);
        run_active = 1'b0;
        check("key_ok", key_ok, (rej < 0) ? 1'b1 : 1'b0);
        check("n_s_writes", n_sw, exp_n_sw);
        check("n_d_writes", n_dw, exp_nb);
        check("n_chk_start", n_starts, exp_nb);
        repeat (3) tick();
        check("done_held", done, 1'b1);
        g = 0;
        for (int x = 0; x < 256; x++) if (sram[x] !== exp_s[x]) g++;
        check("sbox_final_mismatches", g, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_done", done, 1'b0);
        check("rst_key_ok", key_ok, 1'b0);
        check("rst_chk_start", chk_start, 1'b0);
        check("rst_chk_restart", chk_restart, 1'b0);
        check("rst_chk_data", chk_data, 8'h00);
        check("rst_wren", {s_wren, d_wren}, 2'b00);
        check("rst_s_addr", s_addr, 8'h00);
        check("rst_s_wdata", s_wdata, 8'h00);
        check("rst_d_addr", d_addr, 5'h00);
        check("rst_d_wdata", d_wdata, 8'h00);
        check("rst_rom_addr", rom_addr, 5'h00);
    endtask

    initial begin
        int g, rej;
        rst_n = 1'b0; start = 1'b0; chk_finish = 1'b0; chk_key_wrong = 1'b0;
        for (int x = 0; x < 32; x++) begin rom[x] = 8'h00; d_mem[x] = 8'h00; end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs();

        // identity S-box, known ciphertext; i==j on byte 0
        rom[0] = 8'h63; rom[1] = 8'h66; rom[2] = 8'h00; rom[3] = 8'h00;
        load_sbox(1'b1);
        timing_chk = 1'b1;
        run(1, -1, 1'b0);
        timing_chk = 1'b0;
        check("lit_model_p0", exp_p[0], 8'h61);
        check("lit_model_p1", exp_p[1], 8'h63);
        check("lit_d0", d_mem[0], 8'h61);
        check("lit_d1", d_mem[1], 8'h63);
        check("lit_d2", d_mem[2], 8'h07);
        check("lit_d3", d_mem[3], 8'h0d);
        check("lit_s1_unchanged", sram[1], 8'h01);
        check("lit_s2", sram[2], 8'h03);
        check("lit_s3", sram[3], 8'h05);
        check("lit_s5", sram[5], 8'h02);

        // rejection on byte 0 (key_wrong together with finish), then a slow checker, then mid-run start
        load_sbox(1'b1);
        run(0, 0, 1'b0);
        run(5, -1, 1'b0);
        run(2, -1, 1'b1);

        // reset while the first swap write is on the bus
        load_sbox(1'b0);
        for (int x = 0; x < MSG_LEN; x++) rom[x] = 8'($urandom_range(0, 255));
        begin_run(1, -1);
        g = 0;
        while (!s_wren && g < 50) begin
            tick();
            g++;
        end
        check("reached_wr_si", s_wren, 1'b1);
        rst_n = 1'b0;
        tick();
        run_active = 1'b0;
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        run(0, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            load_sbox(1'b0);
            for (int x = 0; x < MSG_LEN; x++) rom[x] = 8'($urandom_range(0, 255));
            rej = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MSG_LEN - 1)) : -1;
            run(int'($urandom_range(0, 3)), rej, 1'(r % 3 == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
